// File: rtl/fetch_unit.sv
// Two-phase instruction fetch: FETCH reads imem, EXEC resolves next pc.
// Faults (fetch timeout, misaligned target) halt until reset.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic        jump,
    input  logic        adr_r31,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    input  logic [31:0] r31_data,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] instr_q, instr_nx;
    logic [31:0] next_pc;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [3:0]  wait_cnt, wait_nx;
    logic        err_q, err_nx;

    assign pc_plus4   = pc + 32'd4;
    assign br_target  = pc_plus4 + (imm_ext << 2);
    assign jmp_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (adr_r31)
            next_pc = r31_data;
        else if (jump)
            next_pc = jmp_target;
        else if (branch && zero)
            next_pc = br_target;
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr_q;
        wait_nx  = wait_cnt;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                state_nx = FETCH;
                wait_nx  = 4'd0;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_nx = imem_rdata;
                    state_nx = EXEC;
                end else if (wait_cnt == 4'd14) begin
                    // fifteenth unanswered cycle: give up
                    wait_nx  = 4'd15;
                    err_nx   = 1'b1;
                    state_nx = HALT;
                end else begin
                    wait_nx = wait_cnt + 4'd1;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        err_nx   = 1'b1;
                        state_nx = HALT;
                    end else begin
                        pc_nx    = next_pc;
                        wait_nx  = 4'd0;
                        state_nx = FETCH;
                    end
                end
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= 32'd0;
            instr_q  <= 32'd0;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            instr_q  <= instr_nx;
            wait_cnt <= wait_nx;
            err_q    <= err_nx;
        end
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, branches, priority,
// wait/timeout, stall and asynchronous reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, jump, adr_r31, zero, stall;
    logic [31:0] imm_ext, r31_data;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .branch     (branch),
        .jump       (jump),
        .adr_r31    (adr_r31),
        .zero       (zero),
        .imm_ext    (imm_ext),
        .r31_data   (r31_data),
        .stall      (stall),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic chk_exec(input string tag, input logic [31:0] ins);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, ins);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        branch = 0; jump = 0; adr_r31 = 0; zero = 0; stall = 0;
        imm_ext = 0; r31_data = 0;
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_1111;
        #3;
        chk_zero("reset");
        chk("reset_pc4", pc_plus4, 32'd4);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // sequential fetch 0, 4, 8
        step(); chk_fetch("seq0", 32'h0);
        step(); chk_exec("seq0x", 32'h1111_1111);
        chk("seq0_pc4", pc_plus4, 32'h4);
        imem_rdata = 32'h2222_2222;
        step(); chk_fetch("seq4", 32'h4);
        step(); chk_exec("seq4x", 32'h2222_2222);
        imem_rdata = 32'h0800_0004;
        step(); chk_fetch("seq8", 32'h8);
        step(); chk_exec("seq8x", 32'h0800_0004);

        // plain jump to 0x10
        jump = 1;
        step(); chk_fetch("jmp", 32'h10);
        jump = 0;
        imem_rdata = 32'h1000_0000;
        step(); chk_exec("br1x", 32'h1000_0000);

        // taken backward branch: 0x14 - 8 = 0x0C
        branch = 1; zero = 1; imm_ext = 32'hFFFF_FFFE;
        step(); chk_fetch("br_taken", 32'hC);
        branch = 0; zero = 0; imm_ext = 0;
        step(); step(); chk_fetch("seq10", 32'h10);
        step();
        branch = 1; zero = 0; imm_ext = 32'hFFFF_FFFE;
        step(); chk_fetch("br_not", 32'h14);
        branch = 0; imm_ext = 0;

        // three wait cycles then data
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_fetch("wait", 32'h14);
            chk("wait_err", {31'd0, fetch_err}, 32'd0);
        end
        imem_ready = 1; imem_rdata = 32'h3333_3333;
        step(); chk_exec("wait_x", 32'h3333_3333);
        chk("wait_noerr", {31'd0, fetch_err}, 32'd0);

        // stall holds EXEC
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            step(); chk_exec("stall", 32'h3333_3333);
            chk("stall_pc", imem_addr, 32'h14);
        end
        stall = 0; adr_r31 = 1; r31_data = 32'h20;
        step(); chk_fetch("jr20", 32'h20);
        adr_r31 = 0; imem_rdata = 32'h0800_0050;
        step(); chk_exec("jr20x", 32'h0800_0050);

        // all requests at once: jr wins
        adr_r31 = 1; jump = 1; branch = 1; zero = 1;
        r31_data = 32'h100;
        step(); chk_fetch("prio", 32'h100);
        adr_r31 = 0; jump = 0; branch = 0; zero = 0;
        imem_rdata = 32'h0800_0008;
        step();
        jump = 1;
        step(); chk_fetch("jmp20", 32'h20);
        jump = 0; imem_rdata = 32'h4444_4444;
        step(); chk_exec("mis_x", 32'h4444_4444);

        // misaligned jr target halts without moving pc
        adr_r31 = 1; r31_data = 32'h102;
        step();
        chk("mis_err", {31'd0, fetch_err}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_vld", {31'd0, instr_valid}, 32'd0);
        chk("mis_pc", imem_addr, 32'h20);
        adr_r31 = 0;
        step(); step();
        chk("halt_err", {31'd0, fetch_err}, 32'd1);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_pc", imem_addr, 32'h20);
        chk("halt_instr", instr, 32'h4444_4444);

        // recover, then reset in the middle of a fetch
        rst = 0; step(); rst = 1;
        imem_rdata = 32'h5555_5555;
        step(); chk_fetch("rf0", 32'h0);
        step(); chk_exec("rf0x", 32'h5555_5555);
        imem_ready = 0;
        step(); chk_fetch("rf4", 32'h4);
        step();
        #2;
        rst = 0;
        #1;
        chk_zero("async_rst");
        imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk_zero("rst_hold");
        rst = 1;
        step(); chk_fetch("refetch", 32'h0);
        imem_rdata = 32'h6666_6666;
        step(); chk_exec("refetch_x", 32'h6666_6666);

        // address wrap at the top of memory
        adr_r31 = 1; r31_data = 32'hFFFF_FFFC;
        step(); chk_fetch("top", 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        adr_r31 = 0; imem_rdata = 32'h7777_7777;
        step(); chk_exec("top_x", 32'h7777_7777);
        step(); chk_fetch("wrap", 32'h0);

        // fetch timeout
        imem_ready = 0;
        for (int i = 0; i < 14; i++) step();
        chk("to14_req", {31'd0, imem_req}, 32'd1);
        chk("to14_err", {31'd0, fetch_err}, 32'd0);
        step();
        chk("to15_err", {31'd0, fetch_err}, 32'd1);
        chk("to15_req", {31'd0, imem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
